// File: rtl/approx_mult_pkg.sv
// Shared types and elaboration-time helpers for the approximate multiplier engine.
package approx_mult_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ARM,
    RD_A,
    RD_B,
    CAP_B,
    NORM,
    MUL,
    DENORM,
    WR,
    DONE
  } ame_state_t;

  // Maximum normalisation shift: bits that may be discarded below the retained field.
  function automatic int calc_lim(input int data_w, input int trunc_w);
    return data_w - trunc_w;
  endfunction

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/lead_one_normaliser.sv
// Left-shifts an operand until its MSB is set or the shift limit is reached,
// counting the shifts taken.
module lead_one_normaliser #(
  parameter int DATA_W = 16,
  parameter int LIM    = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              clr_cnt,
  input  logic              step,
  output logic [DATA_W-1:0] value,
  output logic [CNT_W-1:0]  count,
  output logic              done
);

  assign done = value[DATA_W-1] | (count == CNT_W'(LIM));

  // Operand shift register and shift count; steps only while not yet normalised.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      value <= '0;
      count <= '0;
    end else if (load) begin
      value <= load_val;
      count <= '0;
    end else if (clr_cnt) begin
      count <= '0;
    end else if (step && !done) begin
      value <= value << 1;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/approx_mult_engine.sv
// Sequences NUM_PAIRS operand pairs from the operand RAM through a truncated
// (or exact) multiply and writes each product to the result RAM.
module approx_mult_engine
  import approx_mult_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int TRUNC_W   = 8,
  parameter int NUM_PAIRS = 8,
  parameter int ADDR_W    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [2*DATA_W-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   pair_cnt
);

  localparam int LIM = calc_lim(DATA_W, TRUNC_W);
  localparam int S_W = cnt_width(LIM);
  localparam int D_W = cnt_width(2 * LIM);
  localparam int P_W = 2 * DATA_W;

  ame_state_t state, state_nx;

  logic                 mode_q;
  logic [P_W-1:0]       prod;
  logic [D_W-1:0]       d_cnt;
  logic [D_W-1:0]       d_calc;
  logic [DATA_W-1:0]    a_val, b_val;
  logic [S_W-1:0]       s_a, s_b;
  logic                 a_done, b_done;
  logic                 ld_a, ld_b, clr_s, norm_step;
  logic [TRUNC_W-1:0]   a_top, b_top;
  logic [2*TRUNC_W-1:0] prod_trunc;
  logic [P_W-1:0]       prod_exact;

  // A lands in RD_B, B in CAP_B; CAP_B also clears A's count so both start from zero.
  assign ld_a      = (state == RD_B);
  assign ld_b      = (state == CAP_B);
  assign clr_s     = (state == CAP_B);
  assign norm_step = (state == NORM);

  lead_one_normaliser #(
    .DATA_W (DATA_W),
    .LIM    (LIM),
    .CNT_W  (S_W)
  ) u_norm_a (
    .clk      (clk),
    .rst      (rst),
    .load     (ld_a),
    .load_val (rd_data),
    .clr_cnt  (clr_s),
    .step     (norm_step),
    .value    (a_val),
    .count    (s_a),
    .done     (a_done)
  );

  lead_one_normaliser #(
    .DATA_W (DATA_W),
    .LIM    (LIM),
    .CNT_W  (S_W)
  ) u_norm_b (
    .clk      (clk),
    .rst      (rst),
    .load     (ld_b),
    .load_val (rd_data),
    .clr_cnt  (1'b0),
    .step     (norm_step),
    .value    (b_val),
    .count    (s_b),
    .done     (b_done)
  );

  assign a_top      = a_val[DATA_W-1 -: TRUNC_W];
  assign b_top      = b_val[DATA_W-1 -: TRUNC_W];
  assign prod_trunc = a_top * b_top;
  assign prod_exact = a_val * b_val;
  assign d_calc     = D_W'(2 * LIM) - D_W'(s_a) - D_W'(s_b);

  assign rd_addr = (pair_cnt << 1) | ADDR_W'(state == RD_B);
  assign wr_addr = pair_cnt;
  assign wr_data = prod;
  assign busy    = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = ARM;
      ARM:    if (!start) state_nx = RD_A;
      RD_A:   state_nx = RD_B;
      RD_B:   state_nx = CAP_B;
      CAP_B:  state_nx = mode_q ? MUL : NORM;
      NORM:   if (a_done && b_done) state_nx = MUL;
      MUL: begin
        if (mode_q || d_calc == '0) state_nx = WR;
        else                        state_nx = DENORM;
      end
      DENORM: if (d_cnt == D_W'(1)) state_nx = WR;
      WR:     state_nx = (pair_cnt == ADDR_W'(NUM_PAIRS - 1)) ? DONE : RD_A;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered Moore strobes, mode latch, pair counter and product datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en    <= 1'b0;
      wr_en    <= 1'b0;
      done     <= 1'b0;
      mode_q   <= 1'b0;
      pair_cnt <= '0;
      prod     <= '0;
      d_cnt    <= '0;
    end else begin
      rd_en <= (state_nx == RD_A) || (state_nx == RD_B);
      wr_en <= (state_nx == WR);
      done  <= (state_nx == DONE);

      if (state == IDLE && start) mode_q <= mode;

      if (state == ARM && state_nx == RD_A)     pair_cnt <= '0;
      else if (state == WR && state_nx == RD_A) pair_cnt <= pair_cnt + 1'b1;

      if (state == MUL) begin
        prod  <= mode_q ? prod_exact : P_W'(prod_trunc);
        d_cnt <= mode_q ? '0 : d_calc;
      end else if (state == DENORM) begin
        prod  <= prod << 1;
        d_cnt <= d_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_engine.sv
// Directed bench: three full runs (approximate, exact, approximate), a mid-run
// reset, and checks of data, addresses, write timing, done pulse and busy.
module tb_approx_mult_engine;

  localparam int DATA_W    = 16;
  localparam int TRUNC_W   = 8;
  localparam int NUM_PAIRS = 3;
  localparam int ADDR_W    = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic                mode = 1'b0;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_data = '0;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [2*DATA_W-1:0] wr_data;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   pair_cnt;

  approx_mult_engine #(
    .DATA_W    (DATA_W),
    .TRUNC_W   (TRUNC_W),
    .NUM_PAIRS (NUM_PAIRS),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .pair_cnt (pair_cnt)
  );

  always #5 clk = ~clk;

  // Operand RAM with one-cycle read latency.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write and done logger, sampled mid-cycle.
  int          wr_cyc_q [$];
  int          wr_adr_q [$];
  int          wr_pc_q  [$];
  logic [31:0] wr_dat_q [$];
  int          done_q   [$];
  always @(negedge clk) begin
    if (wr_en) begin
      wr_cyc_q.push_back(cyc);
      wr_adr_q.push_back(int'(wr_addr));
      wr_pc_q.push_back(int'(pair_cnt));
      wr_dat_q.push_back(wr_data);
    end
    if (done) done_q.push_back(cyc);
  end

  int n_checks = 0;
  int n_errors = 0;
  int t_drop   = 0;

  logic [31:0] exp_dat [3];
  int          exp_rel [3];
  int          exp_done_rel;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_cyc_q.delete();
    wr_adr_q.delete();
    wr_pc_q.delete();
    wr_dat_q.delete();
    done_q.delete();
  endtask

  task automatic load_pairs(input logic [15:0] a0, input logic [15:0] b0,
                            input logic [15:0] a1, input logic [15:0] b1,
                            input logic [15:0] a2, input logic [15:0] b2);
    mem[0] = a0; mem[1] = b0;
    mem[2] = a1; mem[3] = b1;
    mem[4] = a2; mem[5] = b2;
  endtask

  // Raise start for two cycles, drop it, then wait (bounded) for done.
  // mode is flipped after the run starts; the engine must ignore that.
  // pulse_at > 0 raises a stray start for 3 cycles at that offset.
  task automatic do_run(input logic m, input int pulse_at);
    clear_logs();
    @(posedge clk); #1;
    mode  = m;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start  = 1'b0;
    t_drop = cyc;
    mode   = ~m;
    check("busy_in_arm", busy, 1);
    for (int i = 0; i < 200 && done_q.size() == 0; i++) begin
      @(posedge clk); #1;
      if (pulse_at > 0 && cyc - t_drop == pulse_at)     start = 1'b1;
      if (pulse_at > 0 && cyc - t_drop == pulse_at + 3) start = 1'b0;
    end
    check("run_timeout", done_q.size() != 0, 1);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_run(input string name);
    check($sformatf("%s_nwr", name), wr_cyc_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < wr_cyc_q.size()) begin
        check($sformatf("%s_data%0d", name, i), wr_dat_q[i], exp_dat[i]);
        check($sformatf("%s_addr%0d", name, i), wr_adr_q[i], i);
        check($sformatf("%s_pcnt%0d", name, i), wr_pc_q[i], i);
        check($sformatf("%s_wcyc%0d", name, i), wr_cyc_q[i] - t_drop, exp_rel[i]);
      end
    end
    check($sformatf("%s_ndone", name), done_q.size(), 1);
    if (done_q.size() != 0)
      check($sformatf("%s_done_cyc", name), done_q[0] - t_drop, exp_done_rel);
    check($sformatf("%s_busy_after", name), busy, 0);
    check($sformatf("%s_done_after", name), done, 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;

    // Reset state.
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_done", done, 0);
    check("rst_pair_cnt", pair_cnt, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    @(negedge clk) rst = 1'b0;

    // Run 1, approximate: d=0 case, d=8 case, d=16 case; stray start ignored.
    // Latencies 14, 22, 22 -> writes at 14, 36, 58, done at 59.
    load_pairs(16'h00FF, 16'h00FF, 16'hFFFF, 16'h0002, 16'h8000, 16'h8000);
    exp_dat = '{32'h0000FE01, 32'h0001FE00, 32'h40000000};
    exp_rel = '{14, 36, 58};
    exp_done_rel = 59;
    do_run(1'b0, 20);
    check_run("approx1");

    // Run 2, exact: 5 cycles per pair.
    load_pairs(16'hFFFF, 16'h0002, 16'h1234, 16'h0010, 16'hFFFF, 16'hFFFF);
    exp_dat = '{32'h0001FFFE, 32'h00012340, 32'hFFFE0001};
    exp_rel = '{5, 10, 15};
    exp_done_rel = 16;
    do_run(1'b1, 0);
    check_run("exact");

    // Reset during DENORM of the first pair (8000 x 8000, DENORM at offsets 6..21).
    load_pairs(16'h8000, 16'h8000, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    clear_logs();
    @(posedge clk); #1;
    mode  = 1'b0;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start  = 1'b0;
    t_drop = cyc;
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_pair_cnt", pair_cnt, 0);
    check("mid_rst_wr_data", wr_data, 0);
    @(posedge clk); #1;
    check("mid_rst_busy_next", busy, 0);
    @(negedge clk) rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("mid_rst_no_write", wr_cyc_q.size(), 0);
    check("mid_rst_no_done", done_q.size(), 0);
    check("mid_rst_idle", busy, 0);

    // Run 3, approximate: zero operand, partial normalisation, full-scale operands.
    // Latencies 19, 18, 22 -> writes at 19, 37, 59, done at 60.
    load_pairs(16'h0000, 16'h1234, 16'h0F0F, 16'h0001, 16'hFFFF, 16'hFFFF);
    exp_dat = '{32'h00000000, 32'h00000F00, 32'hFE010000};
    exp_rel = '{19, 37, 59};
    exp_done_rel = 60;
    do_run(1'b0, 0);
    check_run("approx3");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
